// File: rtl/data_memory_responder.sv
// data_memory_responder: stalling word RAM behind valid/ready request and response channels.
// A request is served a fixed number of wait states after it is accepted; misaligned or out-of-range addresses return an error.
module data_memory_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_address_i,
    input  logic        req_write_enable_i,
    input  logic [3:0]  req_byte_enable_i,
    input  logic [31:0] req_write_data_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_read_data_o,
    output logic        resp_error_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic        we_q, err_q, err_d;
    logic [3:0]  be_q;
    logic [31:0] ram [0:(1<<ADDR_WIDTH)-1];
    logic        accept, access, a_we, a_err;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_be;
    logic [ADDR_WIDTH-1:0] idx;
    assign req_ready_o      = state_q == S_IDLE;
    assign resp_valid_o     = state_q == S_RESP;
    assign resp_read_data_o = rdata_q;
    assign resp_error_o     = err_q;
    assign accept  = req_valid_i && req_ready_o;
    // With zero wait states the access happens on the accept edge, straight from the inputs.
    assign a_addr  = req_ready_o ? req_address_i      : addr_q;
    assign a_we    = req_ready_o ? req_write_enable_i : we_q;
    assign a_be    = req_ready_o ? req_byte_enable_i  : be_q;
    assign a_wdata = req_ready_o ? req_write_data_i   : wdata_q;
    assign a_err   = (|a_addr[1:0]) || (|a_addr[31:ADDR_WIDTH+2]);
    assign idx     = a_addr[ADDR_WIDTH+1:2];
    // The counter starts at WAIT_STATES and the access fires once it has run down to zero,
    // which puts the response WAIT_STATES+1 edges after the accept edge.
    assign access  = (accept && WAIT_STATES == 0) || (state_q == S_WAIT && cnt_q == 4'd0);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = accept ? (WAIT_STATES == 0 ? S_RESP : S_WAIT) : S_IDLE;
                cnt_d   = accept ? 4'(WAIT_STATES) : cnt_q;
            end
            S_WAIT: begin
                state_d = access ? S_RESP : S_WAIT;
                cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = resp_ready_i ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
        rdata_d = access ? ((a_err || a_we) ? 32'd0 : ram[idx]) : rdata_q;
        err_d   = access ? a_err : err_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q  <= req_address_i;
                we_q    <= req_write_enable_i;
                be_q    <= req_byte_enable_i;
                wdata_q <= req_write_data_i;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (access && a_we && !a_err)
            for (int b = 0; b < 4; b++)
                if (a_be[b]) ram[idx][8*b +: 8] <= a_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed vectors against a 2-wait-state responder and a zero-wait-state responder.
module tb_data_memory_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wd = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_data;
    logic        z_valid = 1'b0, z_we = 1'b0;
    logic [31:0] z_addr = '0, z_wd = '0;
    logic [3:0]  z_be = '0;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_data;
    int          n = 0, errs = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_address_i(req_addr), .req_write_enable_i(req_we),
        .req_byte_enable_i(req_be), .req_write_data_i(req_wd),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_read_data_o(resp_data), .resp_error_o(resp_err)
    );

    data_memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(z_valid), .req_ready_o(z_req_ready),
        .req_address_i(z_addr), .req_write_enable_i(z_we),
        .req_byte_enable_i(z_be), .req_write_data_i(z_wd),
        .resp_valid_o(z_resp_valid), .resp_ready_i(1'b1),
        .resp_read_data_o(z_resp_data), .resp_error_o(z_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the 2-wait-state instance; hold = cycles resp_ready stays low in RESP,
    // rst_mid = end the response with a mid-cycle reset instead of a handshake.
    task automatic xfer(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                        input int hold, input bit rst_mid);
        int lat;
        @(posedge clk); #1;
        check("req_ready idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = a; req_we = we; req_be = be; req_wd = wd;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        check("rdata", resp_data, ed);
        check("error", {31'd0, resp_err}, {31'd0, ee});
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_addr = $urandom; req_we = 1'($urandom);
            req_be = 4'($urandom); req_wd = $urandom;
            @(posedge clk); #1;
            check("hold valid", {31'd0, resp_valid}, 32'd1);
            check("hold rdata", resp_data, ed);
            check("hold error", {31'd0, resp_err}, {31'd0, ee});
            check("hold req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        if (rst_mid) begin
            #2 rst_n = 1'b0;
            #1;
            check("async rst valid", {31'd0, resp_valid}, 32'd0);
            check("async rst rdata", resp_data, 32'd0);
            check("async rst error", {31'd0, resp_err}, 32'd0);
            #1 rst_n = 1'b1;
        end else begin
            resp_ready = 1'b1;
            @(posedge clk); #1;
            check("valid after handshake", {31'd0, resp_valid}, 32'd0);
        end
        resp_ready = 1'b1;
    endtask

    initial begin
        int seen;
        #1 rst_n = 1'b0;
        #1;
        check("reset valid", {31'd0, resp_valid}, 32'd0);
        check("reset rdata", resp_data, 32'd0);
        check("reset error", {31'd0, resp_err}, 32'd0);
        #10 rst_n = 1'b1;
        #1;
        check("ready after reset", {31'd0, req_ready}, 32'd1);

        xfer(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b0);
        xfer(32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        xfer(32'h10, 1'b1, 4'b0001, 32'h000000AA, 32'h0, 1'b0, 0, 1'b0);
        xfer(32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, 0, 1'b0);
        xfer(32'h10, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 0, 1'b0);
        xfer(32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, 0, 1'b0);
        xfer(32'h12, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 0, 1'b0);
        xfer(32'h1000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 0, 1'b0);
        xfer(32'h1012, 1'b1, 4'hF, 32'h11111111, 32'h0, 1'b1, 0, 1'b0);
        xfer(32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, 0, 1'b0);
        xfer(32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, 5, 1'b0);
        xfer(32'h10, 1'b0, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0, 2, 1'b1);

        xfer(32'h20, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h20; req_we = 1'b1; req_be = 4'hF; req_wd = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("dropped store responses", 32'(seen), 32'd0);
        xfer(32'h20, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);

        @(posedge clk); #1;
        z_valid = 1'b1; z_addr = 32'h40; z_we = 1'b1; z_be = 4'hF; z_wd = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("ws0 store valid", {31'd0, z_resp_valid}, 32'd1);
        check("ws0 store ready", {31'd0, z_req_ready}, 32'd0);
        check("ws0 store rdata", z_resp_data, 32'd0);
        z_we = 1'b0; z_be = 4'h0;
        @(posedge clk); #1;
        check("ws0 gap valid", {31'd0, z_resp_valid}, 32'd0);
        check("ws0 gap ready", {31'd0, z_req_ready}, 32'd1);
        @(posedge clk); #1;
        check("ws0 load valid", {31'd0, z_resp_valid}, 32'd1);
        check("ws0 load rdata", z_resp_data, 32'hCAFEF00D);
        check("ws0 load error", {31'd0, z_resp_err}, 32'd0);
        z_addr = 32'h41;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ws0 err valid", {31'd0, z_resp_valid}, 32'd1);
        check("ws0 err rdata", z_resp_data, 32'd0);
        check("ws0 err error", {31'd0, z_resp_err}, 32'd1);
        z_valid = 1'b0;
        @(posedge clk); #1;
        check("ws0 idle valid", {31'd0, z_resp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
